// File: rtl/regfile_access_ctrl.sv
// Command-driven initiator for a 32-entry 2R/1W register file.
// Issues read/write/clear accesses and holds read data in a one-entry response buffer.
module regfile_access_ctrl #(
  parameter int RF_DEPTH   = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addrA,
  input  logic [ADDR_WIDTH-1:0] cmd_addrB,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_dataA,
  output logic [DATA_WIDTH-1:0] rsp_dataB,
  output logic                  clear_done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] rf_WriteAddr,
  output logic                  rf_WriteEn,
  output logic [DATA_WIDTH-1:0] rf_data_i,
  output logic [ADDR_WIDTH-1:0] rf_ReadA,
  output logic [ADDR_WIDTH-1:0] rf_ReadB,
  output logic                  rf_ReadAEn,
  output logic                  rf_ReadBEn,
  input  logic [DATA_WIDTH-1:0] rf_data_oA,
  input  logic [DATA_WIDTH-1:0] rf_data_oB
);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_t;

  localparam logic [1:0]            OP_READ  = 2'd0;
  localparam logic [1:0]            OP_WRITE = 2'd1;
  localparam logic [1:0]            OP_CLEAR = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RF_DEPTH - 1);

  state_t                state_r;
  state_t                state_nxt_s;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic                  accept_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic                  clr_acc_s;
  logic                  rsv_acc_s;
  logic                  last_s;

  assign cmd_ready = (state_r == ST_IDLE) && (!rsp_valid || rsp_ready);
  // Qualifying with Reset_n keeps every file enable low while reset is held.
  assign accept_s  = cmd_valid && cmd_ready && Reset_n;
  assign last_s    = (cnt_r == LAST_IDX);

  // Opcode decode of the accepted command
  always_comb begin
    rd_acc_s  = 1'b0;
    wr_acc_s  = 1'b0;
    clr_acc_s = 1'b0;
    rsv_acc_s = 1'b0;
    case (cmd_op)
      OP_READ:  rd_acc_s  = accept_s;
      OP_WRITE: wr_acc_s  = accept_s;
      OP_CLEAR: clr_acc_s = accept_s;
      default:  rsv_acc_s = accept_s;
    endcase
  end

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (clr_acc_s) state_nxt_s = ST_CLEAR;
        else           state_nxt_s = ST_IDLE;
      end
      ST_CLEAR: begin
        if (last_s) state_nxt_s = ST_IDLE;
        else        state_nxt_s = ST_CLEAR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // File port drive
  always_comb begin
    rf_WriteEn   = 1'b0;
    rf_WriteAddr = '0;
    rf_data_i    = '0;
    rf_ReadAEn   = 1'b0;
    rf_ReadBEn   = 1'b0;
    rf_ReadA     = '0;
    rf_ReadB     = '0;
    case (state_r)
      ST_IDLE: begin
        if (rd_acc_s) begin
          rf_ReadAEn = 1'b1;
          rf_ReadBEn = 1'b1;
          rf_ReadA   = cmd_addrA;
          rf_ReadB   = cmd_addrB;
        end else if (wr_acc_s) begin
          rf_WriteEn   = 1'b1;
          rf_WriteAddr = cmd_addrA;
          rf_data_i    = cmd_data;
        end else begin
          rf_WriteEn = 1'b0;
        end
      end
      ST_CLEAR: begin
        rf_WriteEn   = Reset_n;
        rf_WriteAddr = cnt_r;
        rf_data_i    = '0;
      end
      default: rf_WriteEn = 1'b0;
    endcase
  end

  // Clear sweep counter; rests at zero outside CLEAR
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_r <= '0;
    end else if (state_r == ST_CLEAR && !last_s) begin
      cnt_r <= cnt_r + 1'b1;
    end else begin
      cnt_r <= '0;
    end
  end

  // Response buffer: a new read refills in the same edge that drains the old one
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rsp_valid <= 1'b0;
      rsp_dataA <= '0;
      rsp_dataB <= '0;
    end else if (rd_acc_s) begin
      rsp_valid <= 1'b1;
      rsp_dataA <= rf_data_oA;
      rsp_dataB <= rf_data_oB;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

  // Completion pulse and sticky reserved-opcode flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      clear_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      clear_done <= (state_r == ST_CLEAR) && last_s;
      err        <= err || rsv_acc_s;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: behavioural register file plus a shadow-model scoreboard
// of expected read responses.
module tb_regfile_access_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int N  = 32;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          cmd_valid, cmd_ready, rsp_valid, rsp_ready, clear_done, err;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addrA, cmd_addrB, rf_WriteAddr, rf_ReadA, rf_ReadB;
  logic [DW-1:0] cmd_data, rsp_dataA, rsp_dataB, rf_data_i, rf_data_oA, rf_data_oB;
  logic          rf_WriteEn, rf_ReadAEn, rf_ReadBEn;

  logic [DW-1:0]   mem    [N];
  logic [DW-1:0]   shadow [N];
  logic [2*DW-1:0] sb_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  regfile_access_ctrl #(.RF_DEPTH(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addrA(cmd_addrA), .cmd_addrB(cmd_addrB), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dataA(rsp_dataA), .rsp_dataB(rsp_dataB),
    .clear_done(clear_done), .err(err), .rf_WriteAddr(rf_WriteAddr), .rf_WriteEn(rf_WriteEn),
    .rf_data_i(rf_data_i), .rf_ReadA(rf_ReadA), .rf_ReadB(rf_ReadB), .rf_ReadAEn(rf_ReadAEn),
    .rf_ReadBEn(rf_ReadBEn), .rf_data_oA(rf_data_oA), .rf_data_oB(rf_data_oB)
  );

  always #5 Clk = ~Clk;

  // Register file: synchronous write, combinational read gated by enable
  always @(posedge Clk) if (rf_WriteEn) mem[rf_WriteAddr] <= rf_data_i;
  assign rf_data_oA = rf_ReadAEn ? mem[rf_ReadA] : '0;
  assign rf_data_oB = rf_ReadBEn ? mem[rf_ReadB] : '0;

  // One clock; the scoreboard pops when the consumer takes a response
  task automatic tick();
    logic [2*DW-1:0] exp;
    @(negedge Clk);
    if (Reset_n && rsp_valid && rsp_ready) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got %h/%h, required no response", rsp_dataA, rsp_dataB);
      end else begin
        exp = sb_q.pop_front();
        if ({rsp_dataA, rsp_dataB} !== exp) begin
          n_fail++;
          $display("FAIL rsp_data: got %h/%h, required %h/%h",
                   rsp_dataA, rsp_dataB, exp[2*DW-1:DW], exp[DW-1:0]);
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                      input logic [DW-1:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_addrA = a; cmd_addrB = b; cmd_data = d;
    #1;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    n_cmp++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: cmd_ready=%b, required 1 within 100 cycles", cmd_ready);
    end else begin
      if (op == 2'd0) sb_q.push_back({shadow[a], shadow[b]});
      if (op == 2'd1) shadow[a] = d;
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic fill(input logic [DW-1:0] mult);
    for (int i = 0; i < N; i++) send(2'd1, AW'(i), '0, DW'(i) * mult);
  endtask

  task automatic read_all();
    for (int i = 0; i < N / 2; i++) send(2'd0, AW'(2 * i), AW'(2 * i + 1), '0);
    tick();
    n_cmp++;
    if (sb_q.size() != 0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: queue=%0d rsp_valid=%b, required 0/0", sb_q.size(), rsp_valid);
    end
  endtask

  task automatic test_reset();
    #1 Reset_n = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'd0;
    #1;
    n_cmp++;
    if ({rsp_valid, clear_done, err, rf_ReadAEn, rf_ReadBEn} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: v/cd/err/rdA/rdB=%b%b%b%b%b, required 00000",
               rsp_valid, clear_done, err, rf_ReadAEn, rf_ReadBEn);
    end
    n_cmp++;
    if (rsp_dataA !== 32'h0 || rsp_dataB !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h, required 0/0", rsp_dataA, rsp_dataB);
    end
    cmd_op = 2'd1;
    #1;
    n_cmp++;
    if (rf_WriteEn !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wen: got %b, required 0", rf_WriteEn);
    end
    cmd_valid = 1'b0;
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    fill(32'h01010101);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addrA = 5'd5; cmd_data = 32'hDEADBEEF;
    #1;
    n_cmp++;
    if (!(cmd_ready === 1'b1 && rf_WriteEn === 1'b1 && rf_WriteAddr === 5'd5 &&
          rf_data_i === 32'hDEADBEEF && rf_ReadAEn === 1'b0)) begin
      n_fail++;
      $display("FAIL write_pins: rdy=%b wen=%b addr=%0d data=%h rdA=%b, required 1 1 5 deadbeef 0",
               cmd_ready, rf_WriteEn, rf_WriteAddr, rf_data_i, rf_ReadAEn);
    end
    shadow[5] = 32'hDEADBEEF;
    tick();
    rsp_ready = 1'b0;
    cmd_op = 2'd0; cmd_addrA = 5'd5; cmd_addrB = 5'd0;
    #1;
    n_cmp++;
    if (!(rf_ReadAEn === 1'b1 && rf_ReadBEn === 1'b1 && rf_ReadA === 5'd5 &&
          rf_ReadB === 5'd0 && rf_WriteEn === 1'b0)) begin
      n_fail++;
      $display("FAIL read_pins: enA=%b enB=%b A=%0d B=%0d wen=%b, required 1 1 5 0 0",
               rf_ReadAEn, rf_ReadBEn, rf_ReadA, rf_ReadB, rf_WriteEn);
    end
    sb_q.push_back({32'hDEADBEEF, shadow[0]});
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_dataA !== 32'hDEADBEEF || rsp_dataB !== 32'h0) begin
      n_fail++;
      $display("FAIL read_after_write: v=%b A=%h B=%h, required 1 deadbeef 00000000",
               rsp_valid, rsp_dataA, rsp_dataB);
    end
    rsp_ready = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    send(2'd0, 5'd3, 5'd7, '0);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addrA = 5'd9; cmd_addrB = 5'd12;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b0 || rf_ReadAEn !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_dataA !== shadow[3] || rsp_dataB !== shadow[7]) begin
        n_fail++;
        $display("FAIL stall_%0d: rdy=%b enA=%b v=%b A=%h B=%h, required 0 0 1 %h %h", k,
                 cmd_ready, rf_ReadAEn, rsp_valid, rsp_dataA, rsp_dataB, shadow[3], shadow[7]);
      end
      tick();
    end
    rsp_ready = 1'b1;
    send(2'd0, 5'd9, 5'd12, '0);
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL refill_valid: got %b, required 1", rsp_valid);
    end
    tick();
  endtask

  task automatic test_clear();
    int pulses;
    pulses = 0;
    rsp_ready = 1'b1;
    fill(32'h11111111);
    cmd_valid = 1'b1; cmd_op = 2'd2;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1 || rf_WriteEn !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_accept: rdy=%b wen=%b, required 1 0", cmd_ready, rf_WriteEn);
    end
    tick();
    cmd_op = 2'd0;
    for (int k = 0; k < N; k++) begin
      if (clear_done === 1'b1) pulses++;
      n_cmp++;
      if (!(cmd_ready === 1'b0 && rf_WriteEn === 1'b1 && rf_WriteAddr === AW'(k) &&
            rf_data_i === 32'h0 && rf_ReadAEn === 1'b0)) begin
        n_fail++;
        $display("FAIL clear_cycle_%0d: rdy=%b wen=%b addr=%0d data=%h, required 0 1 %0d 0",
                 k, cmd_ready, rf_WriteEn, rf_WriteAddr, rf_data_i, k);
      end
      tick();
    end
    cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if (clear_done !== 1'b1 || cmd_ready !== 1'b1 || rf_WriteEn !== 1'b0 || pulses != 0) begin
      n_fail++;
      $display("FAIL clear_end: cd=%b rdy=%b wen=%b early=%0d, required 1 1 0 0",
               clear_done, cmd_ready, rf_WriteEn, pulses);
    end
    tick();
    n_cmp++;
    if (clear_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_pulse_width: got %b, required 0", clear_done);
    end
    for (int i = 0; i < N; i++) shadow[i] = '0;
    read_all();
  endtask

  task automatic test_reset_in_clear();
    rsp_ready = 1'b1;
    fill(32'h11111111);
    send(2'd2, '0, '0, '0);
    repeat (10) tick();
    Reset_n = 1'b0;
    #1;
    n_cmp++;
    if (rf_WriteEn !== 1'b0 || cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_clear: wen=%b rdy=%b v=%b, required 0 1 0",
               rf_WriteEn, cmd_ready, rsp_valid);
    end
    for (int i = 0; i < 10; i++) shadow[i] = '0;
    tick();
    tick();
    Reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (clear_done !== 1'b0 || rf_WriteEn !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_no_done_%0d: cd=%b wen=%b, required 0 0", k, clear_done, rf_WriteEn);
      end
      tick();
    end
    read_all();
  endtask

  task automatic test_reserved();
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_op = 2'd3; cmd_addrA = 5'd4; cmd_addrB = 5'd1;
    #1;
    n_cmp++;
    if ({cmd_ready, rf_WriteEn, rf_ReadAEn, rf_ReadBEn, err} !== 5'b10000) begin
      n_fail++;
      $display("FAIL rsv_accept: rdy/wen/enA/enB/err=%b%b%b%b%b, required 10000",
               cmd_ready, rf_WriteEn, rf_ReadAEn, rf_ReadBEn, err);
    end
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsv_err: err=%b v=%b, required 1 0", err, rsp_valid);
    end
    send(2'd1, 5'd4, '0, 32'h12345678);
    send(2'd0, 5'd4, 5'd1, '0);
    tick();
    n_cmp++;
    if (err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
    Reset_n = 1'b0;
    #1;
    n_cmp++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_reset: got %b, required 0", err);
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a, b;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a = AW'($urandom_range(0, N - 1));
      b = AW'($urandom_range(0, N - 1));
      send(2'd0, a, b, '0);
      n_cmp++;
      if (rsp_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stream_valid_%0d: got %b, required 1", k, rsp_valid);
      end
    end
    tick();
    n_cmp++;
    if (rsp_valid !== 1'b0 || sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: v=%b queue=%0d, required 0 0", rsp_valid, sb_q.size());
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addrA = '0; cmd_addrB = '0; cmd_data = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write_read();
    test_backpressure();
    test_clear();
    test_reset_in_clear();
    test_reserved();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
